// File: rtl/wb_slave_mux_to.sv
// Registered Wishbone slave mux: decodes adr[19:16] into one-hot slave strobes and
// force-terminates unmapped or hung accesses with a default word, counting each one.
module wb_slave_mux_to #(
    parameter int unsigned NSLV         = 4,
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] DEFAULT_DATA = 32'hDEADBEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 m_cyc_i,
    input  logic                 m_stb_i,
    input  logic                 m_we_i,
    input  logic [31:0]          m_adr_i,
    input  logic [31:0]          m_dat_i,
    input  logic [3:0]           m_sel_i,
    output logic [31:0]          m_dat_o,
    output logic                 m_ack_o,
    output logic                 s_cyc_o,
    output logic                 s_we_o,
    output logic [31:0]          s_adr_o,
    output logic [31:0]          s_dat_o,
    output logic [3:0]           s_sel_o,
    output logic [NSLV-1:0]      s_stb_o,
    input  logic [NSLV*32-1:0]   s_dat_i,
    input  logic [NSLV-1:0]      s_ack_i,
    output logic [7:0]           to_cnt_o,
    output logic                 to_irq_o,
    input  logic                 to_clr_i
);

    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {IDLE, BUSY, ERR, RESP} state_t;

    state_t          state, state_d;
    logic [3:0]      slot, slot_d;
    logic [TW-1:0]   timer, timer_d;
    logic [31:0]     m_dat_d, s_adr_d, s_dat_d;
    logic            m_ack_d, s_cyc_d, s_we_d, to_irq_d, forced;
    logic [3:0]      s_sel_d;
    logic [NSLV-1:0] s_stb_d;
    logic [7:0]      to_cnt_d;
    logic [31:0]     slot_dat;
    logic            slot_ack;
    logic            mapped;

    // Select the latched slot's read data and ack; other slaves' acks are ignored
    always_comb begin
        slot_dat = '0;
        slot_ack = 1'b0;
        for (int i = 0; i < int'(NSLV); i++) begin
            if (slot == 4'(i)) begin
                slot_dat = s_dat_i[32*i +: 32];
                slot_ack = s_ack_i[i];
            end
        end
    end

    assign mapped = {1'b0, m_adr_i[19:16]} < 5'(NSLV);

    always_comb begin
        state_d  = state;
        slot_d   = slot;
        timer_d  = timer;
        m_dat_d  = m_dat_o;
        m_ack_d  = 1'b0;
        s_cyc_d  = s_cyc_o;
        s_we_d   = s_we_o;
        s_adr_d  = s_adr_o;
        s_dat_d  = s_dat_o;
        s_sel_d  = s_sel_o;
        s_stb_d  = s_stb_o;
        forced   = 1'b0;
        to_cnt_d = to_cnt_o;
        to_irq_d = to_irq_o;

        case (state)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    s_cyc_d = 1'b1;
                    s_we_d  = m_we_i;
                    s_adr_d = m_adr_i;
                    s_dat_d = m_dat_i;
                    s_sel_d = m_sel_i;
                    slot_d  = m_adr_i[19:16];
                    timer_d = '0;
                    s_stb_d = '0;
                    if (mapped) begin
                        for (int i = 0; i < int'(NSLV); i++) begin
                            s_stb_d[i] = (m_adr_i[19:16] == 4'(i));
                        end
                        state_d = BUSY;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            BUSY: begin
                if (!m_cyc_i) begin
                    s_stb_d = '0;
                    s_cyc_d = 1'b0;
                    state_d = IDLE;
                end else if (slot_ack) begin
                    m_dat_d = slot_dat;
                    s_stb_d = '0;
                    s_cyc_d = 1'b0;
                    m_ack_d = 1'b1;
                    state_d = RESP;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    m_dat_d = DEFAULT_DATA;
                    s_stb_d = '0;
                    s_cyc_d = 1'b0;
                    forced  = 1'b1;
                    m_ack_d = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            ERR: begin
                m_dat_d = DEFAULT_DATA;
                s_cyc_d = 1'b0;
                forced  = 1'b1;
                m_ack_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear coinciding with a forced termination still records that event
        if (to_clr_i) begin
            to_cnt_d = forced ? 8'd1 : 8'd0;
        end else if (forced && (to_cnt_o != 8'hFF)) begin
            to_cnt_d = to_cnt_o + 8'd1;
        end
        to_irq_d = forced | (to_irq_o & ~to_clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            slot     <= '0;
            timer    <= '0;
            m_dat_o  <= '0;
            m_ack_o  <= 1'b0;
            s_cyc_o  <= 1'b0;
            s_we_o   <= 1'b0;
            s_adr_o  <= '0;
            s_dat_o  <= '0;
            s_sel_o  <= '0;
            s_stb_o  <= '0;
            to_cnt_o <= '0;
            to_irq_o <= 1'b0;
        end else begin
            state    <= state_d;
            slot     <= slot_d;
            timer    <= timer_d;
            m_dat_o  <= m_dat_d;
            m_ack_o  <= m_ack_d;
            s_cyc_o  <= s_cyc_d;
            s_we_o   <= s_we_d;
            s_adr_o  <= s_adr_d;
            s_dat_o  <= s_dat_d;
            s_sel_o  <= s_sel_d;
            s_stb_o  <= s_stb_d;
            to_cnt_o <= to_cnt_d;
            to_irq_o <= to_irq_d;
        end
    end

endmodule

// File: tb/tb_wb_slave_mux_to.sv
// Scoreboard bench for wb_slave_mux_to: driver queues expected read data, a monitor
// compares it on every m_ack_o; directed checks cover strobes, timing and counters.
module tb_wb_slave_mux_to;

    localparam int unsigned NSLV = 4;

    logic               clk, rst;
    logic               m_cyc, m_stb, m_we;
    logic [31:0]        m_adr, m_dat_w;
    logic [3:0]         m_sel;
    logic [31:0]        m_dat_r;
    logic               m_ack;
    logic               s_cyc, s_we;
    logic [31:0]        s_adr, s_dat_w;
    logic [3:0]         s_sel;
    logic [NSLV-1:0]    s_stb;
    logic [NSLV*32-1:0] s_dat_r;
    logic [NSLV-1:0]    s_ack;
    logic [7:0]         to_cnt;
    logic               to_irq, to_clr;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Values observed by the driver during the last transaction
    int          ackc, stb_hi;
    logic [NSLV-1:0] stb1, stb_after;
    logic        we1, cyc_after;
    logic [31:0] sdat1;
    logic [3:0]  sel1;

    wb_slave_mux_to #(.NSLV(NSLV), .TIMEOUT(255), .DEFAULT_DATA(32'hDEADBEEF)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat_w), .m_sel_i(m_sel),
        .m_dat_o(m_dat_r), .m_ack_o(m_ack),
        .s_cyc_o(s_cyc), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_dat_w),
        .s_sel_o(s_sel), .s_stb_o(s_stb), .s_dat_i(s_dat_r), .s_ack_i(s_ack),
        .to_cnt_o(to_cnt), .to_irq_o(to_irq), .to_clr_i(to_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every master ack must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && m_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got data %h expected no ack", m_dat_r);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (m_dat_r !== e) begin
                    errors++;
                    $display("FAIL ack_data: got %h expected %h", m_dat_r, e);
                end
            end
        end
    end

    // One master transaction; cycle 0 is the cycle the request is sampled in.
    // ack_cyc/clr_cyc/abort_cyc of 0 mean "never".
    task automatic txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, input int slv, input int ack_cyc, input logic [31:0] sdat,
                       input int clr_cyc, input int abort_cyc, input logic push,
                       input logic [31:0] exp_dat);
        int limit;
        limit = (abort_cyc != 0) ? abort_cyc + 3 : 300;
        ackc = -1; stb_hi = 0;
        if (push) exp_q.push_back(exp_dat);
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = adr; m_dat_w = dat; m_sel = sel; m_we = we;
        s_dat_r[32*slv +: 32] = sdat;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
            s_ack = '0;
            if (c == ack_cyc) s_ack[slv] = 1'b1;
            to_clr = (c == clr_cyc);
            if (abort_cyc != 0 && c == abort_cyc) begin
                m_cyc = 1'b0; m_stb = 1'b0;
            end
            @(negedge clk);
            if (s_stb != '0) stb_hi++;
            if (c == 1) begin
                stb1 = s_stb; we1 = s_we; sdat1 = s_dat_w; sel1 = s_sel;
            end
            if (abort_cyc != 0 && c == abort_cyc + 1) begin
                stb_after = s_stb; cyc_after = s_cyc;
            end
            if (m_ack) begin
                ackc = c;
                break;
            end
        end
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; s_ack = '0; to_clr = 1'b0;
    endtask

    task automatic unmapped();
        txn(32'h3007_0000, 32'h0, 4'hF, 1'b0, 0, 0, 32'h0, 0, 0, 1'b1, 32'hDEADBEEF);
    endtask

    initial begin
        rst = 1'b1; m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_dat_w = '0; m_sel = '0;
        s_dat_r = '0; s_ack = '0; to_clr = 0;
        #12;
        chk("rst_m_dat", m_dat_r, 32'h0);
        chk("rst_m_ack", 32'(m_ack), 32'h0);
        chk("rst_s_stb", 32'(s_stb), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc), 32'h0);
        chk("rst_to_cnt", 32'(to_cnt), 32'h0);
        chk("rst_to_irq", 32'(to_irq), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Read slot 1, slave acks one cycle after its strobe
        txn(32'h3001_0004, 32'h0, 4'hF, 1'b0, 1, 2, 32'h1234_5678, 0, 0, 1'b1, 32'h1234_5678);
        chk("rd_stb1", 32'(stb1), 32'h2);
        chk("rd_ack_cycle", 32'(ackc), 32'd3);
        chk("rd_to_cnt", 32'(to_cnt), 32'h0);

        // Write slot 0, zero-wait slave
        txn(32'h3000_0008, 32'hA5A5_A5A5, 4'b0011, 1'b1, 0, 1, 32'h0BAD_F00D, 0, 0, 1'b1, 32'h0BAD_F00D);
        chk("wr_stb1", 32'(stb1), 32'h1);
        chk("wr_we1", 32'(we1), 32'h1);
        chk("wr_dat1", sdat1, 32'hA5A5_A5A5);
        chk("wr_sel1", 32'(sel1), 32'h3);
        chk("wr_ack_cycle", 32'(ackc), 32'd2);

        // Unmapped window
        unmapped();
        chk("um_stb1", 32'(stb1), 32'h0);
        chk("um_ack_cycle", 32'(ackc), 32'd2);
        chk("um_to_cnt", 32'(to_cnt), 32'd1);
        chk("um_to_irq", 32'(to_irq), 32'h1);

        // Ack arrives in the timeout cycle: ack wins
        txn(32'h3003_0000, 32'h0, 4'hF, 1'b0, 3, 255, 32'h5555_AAAA, 0, 0, 1'b1, 32'h5555_AAAA);
        chk("race_ack_cycle", 32'(ackc), 32'd256);
        chk("race_to_cnt", 32'(to_cnt), 32'd1);

        // Slot 2 never acks
        txn(32'h3002_0000, 32'h0, 4'hF, 1'b0, 2, 0, 32'h0, 0, 0, 1'b1, 32'hDEADBEEF);
        chk("to_stb_cycles", 32'(stb_hi), 32'd255);
        chk("to_ack_cycle", 32'(ackc), 32'd256);
        chk("to_to_cnt", 32'(to_cnt), 32'd2);

        // Clear alone
        @(posedge clk); #1 to_clr = 1'b1;
        @(posedge clk); #1 to_clr = 1'b0;
        chk("clr_to_cnt", 32'(to_cnt), 32'd0);
        chk("clr_to_irq", 32'(to_irq), 32'd0);

        // Clear coinciding with a timeout termination, count 5 beforehand
        for (int i = 0; i < 5; i++) unmapped();
        chk("pre_to_cnt", 32'(to_cnt), 32'd5);
        txn(32'h3002_0000, 32'h0, 4'hF, 1'b0, 2, 0, 32'h0, 255, 0, 1'b1, 32'hDEADBEEF);
        chk("clrto_to_cnt", 32'(to_cnt), 32'd1);
        chk("clrto_to_irq", 32'(to_irq), 32'd1);

        // Saturation
        for (int i = 0; i < 256; i++) unmapped();
        chk("sat_to_cnt", 32'(to_cnt), 32'd255);

        // Master abort in BUSY cycle 3
        @(posedge clk); #1 to_clr = 1'b1;
        @(posedge clk); #1 to_clr = 1'b0;
        txn(32'h3000_0010, 32'h0, 4'hF, 1'b0, 0, 0, 32'h0, 0, 3, 1'b0, 32'h0);
        chk("abort_stb_after", 32'(stb_after), 32'h0);
        chk("abort_cyc_after", 32'(cyc_after), 32'h0);
        chk("abort_no_ack", 32'(ackc), 32'hFFFF_FFFF);
        chk("abort_to_cnt", 32'(to_cnt), 32'd0);

        // Asynchronous reset mid-BUSY
        unmapped();
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h3001_0000; m_we = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_stb", 32'(s_stb), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("arst_s_stb", 32'(s_stb), 32'h0);
        chk("arst_s_cyc", 32'(s_cyc), 32'h0);
        chk("arst_m_dat", m_dat_r, 32'h0);
        chk("arst_to_cnt", 32'(to_cnt), 32'h0);
        chk("arst_to_irq", 32'(to_irq), 32'h0);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_m_ack", 32'(m_ack), 32'h0);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
